// File: rtl/cache_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_check_pkg
// Description : Shared encodings and helpers for the cache traffic checker.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_check_pkg;

  typedef enum logic [1:0] {
    MODE_WTHRU   = 2'd0,
    MODE_ASSOC   = 2'd1,
    MODE_EVICT   = 2'd2,
    MODE_RECHECK = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] WE_ALL = 4'b1111;

  function automatic logic [31:0] exp_data(input logic [31:0] addr,
                                           input logic [31:0] pattern);
    return addr ^ pattern;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : cache_addr_seq
// Description : Way/word entry sequencer producing current and next-cycle
//               address/data plus the last-entry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_addr_seq
  import cache_check_pkg::*;
#(
  parameter int          WAYS       = 4,
  parameter int          WORDS      = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] WAY_STRIDE = 32'h0010_0000,
  parameter logic [31:0] PATTERN    = 32'h5A5A_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_advance,
  input  logic        i_extra_way,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [31:0] o_addr_nxt,
  output logic [31:0] o_data_nxt,
  output logic        o_last
);

  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ENT_W  = $clog2((WAYS + 1) * WORDS) + 1;
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
  localparam logic [ENT_W-1:0]  LAST_N    = ENT_W'(WAYS * WORDS - 1);
  localparam logic [ENT_W-1:0]  LAST_X    = ENT_W'((WAYS + 1) * WORDS - 1);

  logic [WORD_W-1:0] r_word;
  logic [ENT_W-1:0]  r_entry;
  logic [31:0]       r_way_base;

  logic        w_word_last;
  logic [31:0] w_addr_inc;

  assign w_word_last = (r_word == WORD_LAST);
  assign o_last      = (r_entry == (i_extra_way ? LAST_X : LAST_N));
  assign o_addr      = r_way_base + 32'({r_word, 2'b00});
  assign o_data      = exp_data(o_addr, PATTERN);

  // Address of the entry that follows the current one; wraps for the next phase.
  assign w_addr_inc  = o_last      ? BASE_ADDR :
                       w_word_last ? (r_way_base + WAY_STRIDE) :
                                     (o_addr + 32'd4);
  assign o_addr_nxt  = i_clear   ? BASE_ADDR :
                       i_advance ? w_addr_inc : o_addr;
  assign o_data_nxt  = exp_data(o_addr_nxt, PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_entry    <= '0;
      r_way_base <= BASE_ADDR;
    end else if (i_clear || (i_advance && o_last)) begin
      r_word     <= '0;
      r_entry    <= '0;
      r_way_base <= BASE_ADDR;
    end else if (i_advance) begin
      r_entry <= r_entry + 1'b1;
      if (w_word_last) begin
        r_word     <= '0;
        r_way_base <= r_way_base + WAY_STRIDE;
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : cache_traffic_checker
// Description : Self-checking write/read traffic generator for the CPU-side
//               data-cache port, with mismatch counting and stall time-out.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_traffic_checker
  import cache_check_pkg::*;
#(
  parameter int          WAYS       = 4,
  parameter int          WORDS      = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] WAY_STRIDE = 32'h0010_0000,
  parameter logic [31:0] PATTERN    = 32'h5A5A_0000,
  parameter int          MAX_STALLS = 50
) (
  input  logic        cpu_clk_g,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic [31:0] dcache_addr,
  output logic [3:0]  dcache_we,
  output logic        dcache_re,
  output logic [31:0] dcache_din,
  input  logic [31:0] dcache_dout,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] fail_count,
  output logic        timeout,
  output logic [31:0] first_fail_addr,
  output logic [31:0] first_fail_data
);

  localparam int STALL_W = $clog2(MAX_STALLS + 2);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MAX_STALLS);

  state_e              r_state,    w_state_nxt;
  mode_e               r_mode,     w_mode_nxt;
  logic [31:0]         r_addr,     w_addr_nxt;
  logic [31:0]         r_din,      w_din_nxt;
  logic [3:0]          r_we,       w_we_nxt;
  logic                r_re,       w_re_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic [15:0]         r_fail,     w_fail_nxt;
  logic                r_timeout,  w_timeout_nxt;
  logic [31:0]         r_ffa,      w_ffa_nxt;
  logic [31:0]         r_ffd,      w_ffd_nxt;
  logic [STALL_W-1:0]  r_stall_cnt, w_stall_nxt;

  logic        w_clear;
  logic        w_adv;
  logic        w_expire;
  logic        w_last;
  logic        w_extra_way;
  logic [31:0] w_seq_addr;
  logic [31:0] w_seq_data;
  logic [31:0] w_seq_addr_nxt;
  logic [31:0] w_seq_data_nxt;

  assign w_extra_way = (r_mode == MODE_EVICT) || (r_mode == MODE_RECHECK);

  cache_addr_seq #(
    .WAYS       (WAYS),
    .WORDS      (WORDS),
    .BASE_ADDR  (BASE_ADDR),
    .WAY_STRIDE (WAY_STRIDE),
    .PATTERN    (PATTERN)
  ) u_seq (
    .clk         (cpu_clk_g),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_advance   (w_adv),
    .i_extra_way (w_extra_way),
    .o_addr      (w_seq_addr),
    .o_data      (w_seq_data),
    .o_addr_nxt  (w_seq_addr_nxt),
    .o_data_nxt  (w_seq_data_nxt),
    .o_last      (w_last)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_we_nxt      = r_we;
    w_re_nxt      = r_re;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_fail_nxt    = r_fail;
    w_timeout_nxt = r_timeout;
    w_ffa_nxt     = r_ffa;
    w_ffd_nxt     = r_ffd;
    w_stall_nxt   = r_stall_cnt;
    w_addr_nxt    = '0;
    w_din_nxt     = '0;
    w_clear       = 1'b0;
    w_adv         = 1'b0;
    w_expire      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_clear       = 1'b1;
          w_mode_nxt    = mode_e'(mode);
          w_fail_nxt    = '0;
          w_timeout_nxt = 1'b0;
          w_ffa_nxt     = '0;
          w_ffd_nxt     = '0;
          w_done_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
          w_stall_nxt   = '0;
          if (mode == MODE_RECHECK) begin
            w_state_nxt = ST_READ;
            w_re_nxt    = 1'b1;
            w_we_nxt    = '0;
          end else begin
            w_state_nxt = ST_WRITE;
            w_we_nxt    = WE_ALL;
            w_re_nxt    = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        if (stall) begin
          w_expire    = (r_stall_cnt == STALL_LIM);
          w_stall_nxt = r_stall_cnt + 1'b1;
        end else begin
          w_stall_nxt = '0;
          // Write-through mode reads back the same entry before moving on.
          if (r_mode == MODE_WTHRU || w_last) begin
            w_adv       = (r_mode != MODE_WTHRU);
            w_state_nxt = ST_READ;
            w_we_nxt    = '0;
            w_re_nxt    = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (stall) begin
          w_expire    = (r_stall_cnt == STALL_LIM);
          w_stall_nxt = r_stall_cnt + 1'b1;
        end else begin
          w_stall_nxt = '0;
          w_re_nxt    = 1'b0;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (stall) begin
          w_expire    = (r_stall_cnt == STALL_LIM);
          w_stall_nxt = r_stall_cnt + 1'b1;
        end else begin
          w_stall_nxt = '0;
          w_adv       = 1'b1;
          if (dcache_dout != w_seq_data) begin
            if (r_fail != 16'hFFFF) w_fail_nxt = r_fail + 16'd1;
            if (r_fail == 16'd0) begin
              w_ffa_nxt = w_seq_addr;
              w_ffd_nxt = dcache_dout;
            end
          end
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (r_mode == MODE_WTHRU) begin
            w_state_nxt = ST_WRITE;
            w_we_nxt    = WE_ALL;
          end else begin
            w_state_nxt = ST_READ;
            w_re_nxt    = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_expire) begin
      w_timeout_nxt = 1'b1;
      w_we_nxt      = '0;
      w_re_nxt      = 1'b0;
      w_state_nxt   = ST_DONE;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b1;
    end

    if (w_state_nxt != ST_IDLE && w_state_nxt != ST_DONE) begin
      w_addr_nxt = w_seq_addr_nxt;
      w_din_nxt  = (w_we_nxt != 4'd0) ? w_seq_data_nxt : 32'd0;
    end
  end

  always_ff @(posedge cpu_clk_g or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_WTHRU;
      r_addr      <= '0;
      r_din       <= '0;
      r_we        <= '0;
      r_re        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= '0;
      r_timeout   <= 1'b0;
      r_ffa       <= '0;
      r_ffd       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_we        <= w_we_nxt;
      r_re        <= w_re_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_fail      <= w_fail_nxt;
      r_timeout   <= w_timeout_nxt;
      r_ffa       <= w_ffa_nxt;
      r_ffd       <= w_ffd_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  assign dcache_addr     = r_addr;
  assign dcache_we       = r_we;
  assign dcache_re       = r_re;
  assign dcache_din      = r_din;
  assign busy            = r_busy;
  assign done            = r_done;
  assign fail_count      = r_fail;
  assign timeout         = r_timeout;
  assign first_fail_addr = r_ffa;
  assign first_fail_data = r_ffd;

endmodule
`default_nettype wire

// File: tb/tb_cache_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_traffic_checker
// Description : Directed bench with a memory-backed cache responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_traffic_checker;

  localparam logic [31:0] PATTERN = 32'h5A5A_0000;
  localparam logic [31:0] NOFLIP  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] fail_count;
  logic        timeout;
  logic [31:0] first_fail_addr;
  logic [31:0] first_fail_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_traffic_checker dut (
    .cpu_clk_g       (clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .dcache_addr     (dcache_addr),
    .dcache_we       (dcache_we),
    .dcache_re       (dcache_re),
    .dcache_din      (dcache_din),
    .dcache_dout     (dcache_dout),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .fail_count      (fail_count),
    .timeout         (timeout),
    .first_fail_addr (first_fail_addr),
    .first_fail_data (first_fail_data)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
  } op_t;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] flip;
    int          smax;
    bit          repulse;
    logic [15:0] exp_fail;
    logic [31:0] exp_ffa;
    logic [31:0] exp_ffd;
  } vec_t;

  op_t         log_q[$];
  op_t         exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          stall_max   = 0;
  logic [31:0] flip_addr   = NOFLIP;
  bit          force_stall = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cache responder: one request at a time, random stalls, memory-backed data.
  initial begin
    bit          rd_pend = 1'b0;
    int          sleft = -1;
    logic [31:0] rd_data = '0;
    op_t         o;
    stall = 1'b0;
    dcache_dout = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_pend = 1'b0; sleft = -1; stall = 1'b0;
      end else if (force_stall) begin
        stall = 1'b1;
      end else if (rd_pend || dcache_we != 4'd0 || dcache_re) begin
        if (sleft < 0) sleft = (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
        if (sleft > 0) begin
          stall = 1'b1;
          sleft--;
        end else begin
          stall = 1'b0;
          sleft = -1;
          if (rd_pend) begin
            dcache_dout = rd_data;
            rd_pend = 1'b0;
          end else if (dcache_we != 4'd0) begin
            mem[dcache_addr] = dcache_din;
            o.wr = 1'b1; o.addr = dcache_addr; o.din = dcache_din; o.we = dcache_we;
            log_q.push_back(o);
          end else begin
            rd_data = mem.exists(dcache_addr) ? mem[dcache_addr] : 32'd0;
            if (dcache_addr == flip_addr) rd_data = rd_data ^ 32'd1;
            o.wr = 1'b0; o.addr = dcache_addr; o.din = '0; o.we = '0;
            log_q.push_back(o);
            rd_pend = 1'b1;
          end
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  function automatic logic [31:0] ent_addr(input int w, input int k);
    return (w * 32'h0010_0000) + (4 * k);
  endfunction

  task automatic push_op(input bit wr, input logic [31:0] a);
    op_t o;
    o.wr = wr; o.addr = a; o.din = wr ? (a ^ PATTERN) : 32'd0; o.we = wr ? 4'hF : 4'h0;
    exp_q.push_back(o);
  endtask

  task automatic build_exp(input logic [1:0] m);
    int nw;
    exp_q.delete();
    nw = (m >= 2'd2) ? 5 : 4;
    if (m == 2'd0) begin
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 2; k++) begin
          push_op(1'b1, ent_addr(w, k));
          push_op(1'b0, ent_addr(w, k));
        end
    end else begin
      if (m != 2'd3)
        for (int w = 0; w < nw; w++)
          for (int k = 0; k < 2; k++) push_op(1'b1, ent_addr(w, k));
      for (int w = 0; w < nw; w++)
        for (int k = 0; k < 2; k++) push_op(1'b0, ent_addr(w, k));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  cyc;
    int  errs;
    bit  seen;
    stall_max = v.smax;
    flip_addr = v.flip;
    log_q.delete();
    build_exp(v.mode);
    mode  = v.mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), 160'(busy), 160'(1));
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 3000 && !seen) begin
      if (v.repulse && cyc == 3) begin
        start = 1'b1;
        mode  = 2'd3;
      end
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
      cyc++;
    end
    chk($sformatf("v%0d done_seen", idx), 160'(seen), 160'(1));
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d done_held", idx), 160'({done, busy}), 160'(2'b10));
    chk($sformatf("v%0d fail_count", idx), 160'(fail_count), 160'(v.exp_fail));
    chk($sformatf("v%0d first_fail", idx), 160'({first_fail_addr, first_fail_data}),
        160'({v.exp_ffa, v.exp_ffd}));
    chk($sformatf("v%0d timeout", idx), 160'(timeout), 160'(0));
    chk($sformatf("v%0d num_ops", idx), 160'(log_q.size()), 160'(exp_q.size()));
    errs = 0;
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
          log_q[i].din !== exp_q[i].din || log_q[i].we !== exp_q[i].we) errs++;
    chk($sformatf("v%0d op_order_errs", idx), 160'(errs), 160'(0));
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc;
    vecs[0] = '{2'd0, NOFLIP,         0, 1'b1, 16'd0, 32'h0, 32'h0};
    vecs[1] = '{2'd1, 32'h0010_0004,  0, 1'b0, 16'd1, 32'h0010_0004, 32'h5A4A_0005};
    vecs[2] = '{2'd2, NOFLIP,         5, 1'b0, 16'd0, 32'h0, 32'h0};
    vecs[3] = '{2'd3, NOFLIP,         2, 1'b0, 16'd0, 32'h0, 32'h0};
    vecs[4] = '{2'd0, 32'h0030_0004,  3, 1'b0, 16'd1, 32'h0030_0004, 32'h5A6A_0005};

    repeat (10) @(negedge clk);
    chk("reset_outs_in_rst", {dcache_addr, dcache_we, dcache_re, dcache_din, busy, done,
        fail_count, timeout, first_fail_addr, first_fail_data}, 160'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs_after", {dcache_addr, dcache_we, dcache_re, dcache_din, busy, done,
        fail_count, timeout, first_fail_addr, first_fail_data}, 160'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Permanent stall on a pending read: time-out fires on the 51st stall edge.
    force_stall = 1'b1;
    mode  = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_re_pending", 160'({busy, dcache_re}), 160'(2'b11));
    repeat (50) @(negedge clk);
    chk("to_not_yet", 160'({timeout, dcache_re, done}), 160'(3'b010));
    @(negedge clk);
    chk("to_fired", 160'({timeout, dcache_re, done, busy}), 160'(4'b1010));
    chk("to_fail_count", 160'(fail_count), 160'(0));
    force_stall = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a read.
    stall_max = 0;
    flip_addr = NOFLIP;
    mode  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wcyc = 0;
    while (!dcache_re && wcyc < 100) begin
      @(negedge clk);
      wcyc++;
    end
    chk("rst_saw_read", 160'(dcache_re), 160'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {dcache_addr, dcache_we, dcache_re, dcache_din, busy, done,
        fail_count, timeout, first_fail_addr, first_fail_data}, 160'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_outs", {dcache_addr, dcache_we, dcache_re, dcache_din, busy, done}, 160'd0);

    run_vec(vecs[3], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
